sar_search_16_bit: RTL and testbench
====================================

Name: sar_search_16_bit

Overview:
- Successive-approximation search engine: the initiator that drives the 16-bit magnitude comparator.
- Issues trial values on the comparator's A side. The unknown target sits on the comparator's B side.
- Consumes the less/equal/greater flags and converges on the target by binary search, MSB first.
- Used for threshold discovery, ADC-style SAR loops and comparator self-test.

Parameters:
- DATA_WIDTH, 16, width of trial/result words. Only 16 is verified; other values must elaborate and work identically, scaled.

Ports:
- Clock_In  input  1  single clock, all state updates on rising edge
- Reset_In  input  1  asynchronous, active-low reset (0 = reset asserted)
- Start_In  input  1  begin search; sampled only in IDLE
- Trial_Out  output  DATA_WIDTH  current trial value (comparator Data_A_In)
- Trial_Valid_Out  output  1  trial presented, awaiting comparison result
- Result_Valid_In  input  1  comparator flags valid this cycle; may be tied high for a combinational comparator
- Less_In  input  1  trial < target (A_Less_Than_B)
- Equal_In  input  1  trial == target (A_Equal_To_B)
- Greater_In  input  1  trial > target (A_Greater_Than_B)
- Busy_Out  output  1  search in progress
- Done_Out  output  1  one-cycle pulse, search finished
- Found_Out  output  DATA_WIDTH  search result; held until next Start
- Exact_Out  output  1  search terminated on an Equal response; held with Found_Out
- Error_Out  output  1  one-cycle pulse with Done_Out when a response was not one-hot

Behaviour:
- Reset (Reset_In=0, async, any state):
  - State=IDLE.
  - Trial_Out=0, Trial_Valid_Out=0, Busy_Out=0, Done_Out=0, Found_Out=0, Exact_Out=0, Error_Out=0.
  - Internal base register=0, bit index=DATA_WIDTH-1.
- FSM states: IDLE, ISSUE, FINISH.
- IDLE:
  - Start_In=1 → ISSUE on next edge.
  - Load base=0, bit index=15, Trial_Out=0x8000, Trial_Valid_Out=1, Busy_Out=1.
  - Clear Found_Out, Exact_Out.
- ISSUE:
  - Trial_Out is held stable and Trial_Valid_Out stays 1 until a cycle where Result_Valid_In=1. That cycle is the handshake; flags are sampled only then.
  - Trial value is always base | (1<<bit index).
  - Equal only: Found_Out=trial, Exact_Out=1 → FINISH.
  - Less only: base keeps the trial bit.
  - Greater only: base drops the trial bit.
  - After a Less/Greater response:
    - If bit index>0, decrement the bit index and present the next trial the following cycle.
    - If bit index=0, Found_Out=updated base, Exact_Out=0 → FINISH.
  - Non-one-hot flags (none, more than one, or X/Z resolving to non-one-hot): abort. Found_Out=0, Exact_Out=0, Error_Out=1 → FINISH.
- FINISH (one cycle):
  - Done_Out=1, Busy_Out=0, Trial_Valid_Out=0 → IDLE.
  - Error_Out is high only in this cycle, and only for an aborted search.
- Latency with Result_Valid_In tied high: Start at cycle 0; trials at cycles 1..k (k≤16); Done_Out at cycle k+1. Worst case 17 cycles Start→Done.
- Start_In while Busy_Out=1 or in FINISH is ignored; no queuing.
- Arithmetic is unsigned. All 2^16 targets resolve in ≤16 responses. Trial never wraps: max trial 0xFFFF, min 0x0001.
- Reset mid-search: immediate abort, no Done_Out pulse, outputs return to reset values.
- Result_Valid_In outside ISSUE is ignored.

Test Plan:
- Target 0x8000, combinational comparator: first trial 0x8000 returns Equal → Done_Out at cycle 2, Found_Out=0x8000, Exact_Out=1, exactly 1 handshake.
- Target 0x0000: trials 0x8000,0x4000,…,0x0001 all Greater → 16 handshakes, Done_Out at cycle 17, Found_Out=0x0000, Exact_Out=0.
- Target 0xFFFF: trials 0x8000,0xC000,…,0xFFFF; 16th returns Equal → Found_Out=0xFFFF, Exact_Out=1.
- Target 0x1234 with Result_Valid_In asserted every 3rd cycle → Trial_Out stable while waiting, trial sequence 0x8000,0x4000,0x2000,0x1000,0x1800,0x1400,… ends Found_Out=0x1234, Exact_Out=1.
- Error handling:
  - Force Less_In=Greater_In=1 on 2nd handshake → Done_Out and Error_Out pulse together, Found_Out=0.
  - Next Start with a good comparator → normal result, Error_Out=0.
- Reset and Start edge cases:
  - Drive Reset_In=0 mid-search (after 5 handshakes) → all outputs 0 asynchronously, no Done_Out.
  - Start_In pulsed during a busy search → ignored; trial sequence unchanged.

Source files
------------

// File: rtl/sar_search_16_bit.sv
// Successive-approximation search engine: drives trial values into a magnitude
// comparator and binary-searches the target MSB first using its less/equal/greater flags.
module sar_search_16_bit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    output logic [DATA_WIDTH-1:0] Trial_Out,
    output logic                  Trial_Valid_Out,
    input  logic                  Result_Valid_In,
    input  logic                  Less_In,
    input  logic                  Equal_In,
    input  logic                  Greater_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Found_Out,
    output logic                  Exact_Out,
    output logic                  Error_Out
);

    // state  | meaning
    // IDLE   | waiting for Start_In, result registers hold last search
    // ISSUE  | trial presented, waiting for a comparator handshake
    // FINISH | one-cycle Done_Out (and Error_Out on abort)
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FINISH
    } state_t;

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] base, base_nxt;
    logic [DATA_WIDTH-1:0] found, found_nxt;
    logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
    logic                  exact, exact_nxt;
    logic                  err, err_nxt;
    logic [DATA_WIDTH-1:0] trial_bit;
    logic [DATA_WIDTH-1:0] trial;
    logic [DATA_WIDTH-1:0] resolved_base;

    assign trial_bit = DATA_WIDTH'(1) << bit_idx;
    assign trial     = base | trial_bit;

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state   <= ST_IDLE;
            base    <= '0;
            bit_idx <= IDX_MSB;
            found   <= '0;
            exact   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            base    <= base_nxt;
            bit_idx <= bit_idx_nxt;
            found   <= found_nxt;
            exact   <= exact_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        bit_idx_nxt   = bit_idx;
        found_nxt     = found;
        exact_nxt     = exact;
        err_nxt       = err;
        resolved_base = Less_In ? trial : (base & ~trial_bit);
        case (state)
            ST_IDLE: begin
                if (Start_In) begin
                    base_nxt    = '0;
                    bit_idx_nxt = IDX_MSB;
                    found_nxt   = '0;
                    exact_nxt   = 1'b0;
                    err_nxt     = 1'b0;
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Result_Valid_In) begin
                    // anything other than exactly one flag (including X/Z) aborts
                    case ({Less_In, Equal_In, Greater_In})
                        3'b010: begin
                            found_nxt = trial;
                            exact_nxt = 1'b1;
                            state_nxt = ST_FINISH;
                        end
                        3'b100, 3'b001: begin
                            base_nxt = resolved_base;
                            if (bit_idx == '0) begin
                                found_nxt = resolved_base;
                                exact_nxt = 1'b0;
                                state_nxt = ST_FINISH;
                            end else begin
                                bit_idx_nxt = bit_idx - IDX_W'(1);
                            end
                        end
                        default: begin
                            found_nxt = '0;
                            exact_nxt = 1'b0;
                            err_nxt   = 1'b1;
                            state_nxt = ST_FINISH;
                        end
                    endcase
                end
            end
            ST_FINISH: begin
                err_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign Trial_Out       = (state == ST_ISSUE) ? trial : '0;
    assign Trial_Valid_Out = (state == ST_ISSUE);
    assign Busy_Out        = (state == ST_ISSUE);
    assign Done_Out        = (state == ST_FINISH);
    assign Error_Out       = (state == ST_FINISH) && err;
    assign Found_Out       = found;
    assign Exact_Out       = exact;

endmodule

// File: tb/tb_sar_search_16_bit.sv
// Randomized bench for sar_search_16_bit: a behavioural comparator plus a binary-search
// reference model predict every trial, the handshake count and the final result.
module tb_sar_search_16_bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] trial;
    logic        trial_valid;
    logic        result_valid;
    logic        less, equal, greater;
    logic        busy, done, exact, error;
    logic [15:0] found;

    logic [15:0] target;
    logic        bad;
    int          total = 0;
    int          nbad  = 0;

    assign less    = bad ? 1'b1 : (trial < target);
    assign greater = bad ? 1'b1 : (trial > target);
    assign equal   = bad ? 1'b0 : (trial == target);

    sar_search_16_bit #(.DATA_WIDTH(16)) dut (
        .Clock_In        (clk),
        .Reset_In        (rst_n),
        .Start_In        (start),
        .Trial_Out       (trial),
        .Trial_Valid_Out (trial_valid),
        .Result_Valid_In (result_valid),
        .Less_In         (less),
        .Equal_In        (equal),
        .Greater_In      (greater),
        .Busy_Out        (busy),
        .Done_Out        (done),
        .Found_Out       (found),
        .Exact_Out       (exact),
        .Error_Out       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // k-th trial of an ideal binary search: the target's bits above the probe bit, plus the probe bit
    function automatic logic [15:0] exp_trial(input logic [15:0] tgt, input int k);
        logic [15:0] hi_mask;
        logic [15:0] probe;
        hi_mask = 16'hFFFF;
        hi_mask = hi_mask << (16 - k);
        probe   = 16'h0001;
        probe   = probe << (15 - k);
        return (tgt & hi_mask) | probe;
    endfunction

    // number of responses: search stops once the probe reaches the lowest set bit of the target
    function automatic int exp_hs(input logic [15:0] tgt);
        for (int b = 0; b < 16; b++)
            if (tgt[b]) return 16 - b;
        return 16;
    endfunction

    task automatic run_search(input logic [15:0] tgt, input int period, input int bad_hs,
                              input int pulse_at);
        int  cyc, hs, k_exp;
        bit  done_seen;
        k_exp  = (bad_hs > 0) ? bad_hs : exp_hs(tgt);
        target = tgt;
        bad    = 1'b0;
        @(negedge clk);
        start        = 1'b1;
        result_valid = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        hs        = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            bad = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                if (period == 1) check("done_cycle", cyc, k_exp + 1);
                check("handshakes", hs, k_exp);
                check("busy_in_finish", busy, 1'b0);
                check("valid_in_finish", trial_valid, 1'b0);
                check("error_pulse", error, bad_hs > 0);
                check("found", found, (bad_hs > 0) ? 16'h0 : tgt);
                check("exact", exact, (bad_hs == 0) && (tgt != 16'h0));
                start = 1'b1;
            end else begin
                check("busy", busy, 1'b1);
                check("trial_valid", trial_valid, 1'b1);
                check("trial", trial, exp_trial(tgt, hs));
                check("no_error_early", error, 1'b0);
                result_valid = ((cyc % period) == 0);
                if (result_valid && (hs + 1 == bad_hs)) bad = 1'b1;
                if (cyc == pulse_at) start = 1'b1;
                if (result_valid) hs++;
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        @(negedge clk);
        start        = 1'b0;
        bad          = 1'b0;
        result_valid = 1'b1;
        check("idle_done_low", done, 1'b0);
        check("idle_error_low", error, 1'b0);
        check("start_in_finish_ignored", busy, 1'b0);
        check("found_held", found, (bad_hs > 0) ? 16'h0 : tgt);
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    initial begin
        int tgt, per, bh, pa;
        rst_n        = 1'b0;
        start        = 1'b0;
        result_valid = 1'b0;
        target       = 16'h0;
        bad          = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_trial", trial, 16'h0);
        check("rst_valid", trial_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_found", found, 16'h0);
        check("rst_exact", exact, 1'b0);
        check("rst_error", error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_search(16'h8000, 1, 0, 0);
        run_search(16'h0000, 1, 0, 0);
        run_search(16'hFFFF, 1, 0, 0);
        run_search(16'h1234, 3, 0, 0);
        run_search(16'h1234, 1, 2, 0);
        run_search(16'h5A5A, 1, 0, 0);
        run_search(16'h00F0, 1, 0, 3);

        // reset in the middle of a search after five handshakes
        target = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        result_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_trial", trial, exp_trial(16'h0001, 5));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trial", trial, 16'h0);
        check("async_rst_valid", trial_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_found", found, 16'h0);
        check("async_rst_exact", exact, 1'b0);
        check("async_rst_error", error, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 1'b0);
        end
        rst_n        = 1'b1;
        result_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            tgt = $urandom_range(0, 65535);
            per = $urandom_range(1, 3);
            bh  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_hs(16'(tgt))) : 0;
            pa  = $urandom_range(2, 6);
            run_search(16'(tgt), per, bh, pa);
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
